// File: rtl/mem_arbiter_if.sv
// Bus bundle between fetch/memory stages, the arbiter and the data memory.
// The arbiter uses the slave view; the surrounding system uses master.
interface mem_arbiter_if;
    logic        f_Rd;
    logic [15:0] f_Addr;
    logic [15:0] f_DataOut;
    logic        f_Done;
    logic        f_Stall;
    logic        f_err;

    logic        d_Rd;
    logic        d_Wr;
    logic [15:0] d_Addr;
    logic [15:0] d_DataIn;
    logic [15:0] d_DataOut;
    logic        d_Done;
    logic        d_Stall;
    logic        d_err;

    logic        m_Rd;
    logic        m_Wr;
    logic [15:0] m_Addr;
    logic [15:0] m_DataIn;
    logic [15:0] m_DataOut;
    logic        m_Done;
    logic        m_Stall;
    logic        m_err;

    modport slave (
        input  f_Rd, f_Addr,
        output f_DataOut, f_Done, f_Stall, f_err,
        input  d_Rd, d_Wr, d_Addr, d_DataIn,
        output d_DataOut, d_Done, d_Stall, d_err,
        output m_Rd, m_Wr, m_Addr, m_DataIn,
        input  m_DataOut, m_Done, m_Stall, m_err
    );

    modport master (
        output f_Rd, f_Addr,
        input  f_DataOut, f_Done, f_Stall, f_err,
        output d_Rd, d_Wr, d_Addr, d_DataIn,
        input  d_DataOut, d_Done, d_Stall, d_err,
        input  m_Rd, m_Wr, m_Addr, m_DataIn,
        output m_DataOut, m_Done, m_Stall, m_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port fetch/data arbiter in front of one stalling memory.
// ARB_ROUND_ROBIN_EN: ties go to the port not served last.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_rd;
    logic        r_wr;

    logic w_f_req;
    logic w_f_bad;
    logic w_d_any;
    logic w_d_req;
    logic w_d_bad;
    logic w_busy_f;
    logic w_busy_d;
    logic w_f_done;
    logic w_d_done;
    logic w_grant_d;
    logic w_unused;

    assign w_f_req = bus.f_Rd & ~bus.f_Addr[0];
    assign w_f_bad = bus.f_Rd & bus.f_Addr[0];
    assign w_d_any = bus.d_Rd | bus.d_Wr;
    assign w_d_req = (bus.d_Rd ^ bus.d_Wr)
                   & ~bus.d_Addr[0];
    assign w_d_bad = w_d_any & ~w_d_req;

    assign w_busy_f = (r_state == BUSY_F);
    assign w_busy_d = (r_state == BUSY_D);
    assign w_f_done = w_busy_f & bus.m_Done;
    assign w_d_done = w_busy_d & bus.m_Done;

    // Tie-break when both ports present a valid request in IDLE
`ifdef ARB_ROUND_ROBIN_EN
    assign w_grant_d = w_d_req & (~w_f_req | ~r_last);
    assign w_unused  = bus.m_Stall;
`else
    assign w_grant_d = w_d_req;
    assign w_unused  = bus.m_Stall ^ r_last;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state <= BUSY_D;
                        r_last  <= 1'b1;
                        r_addr  <= bus.d_Addr;
                        r_wdata <= bus.d_DataIn;
                        r_rd    <= bus.d_Rd;
                        r_wr    <= bus.d_Wr;
                    end else if (w_f_req) begin
                        r_state <= BUSY_F;
                        r_last  <= 1'b0;
                        r_addr  <= bus.f_Addr;
                        r_rd    <= 1'b1;
                        r_wr    <= 1'b0;
                    end
                end
                BUSY_F, BUSY_D: begin
                    if (bus.m_Done)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_Rd     = r_rd & (w_busy_f | w_busy_d);
    assign bus.m_Wr     = r_wr & (w_busy_f | w_busy_d);
    assign bus.m_Addr   = r_addr;
    assign bus.m_DataIn = r_wdata;

    assign bus.f_Done    = w_f_done;
    assign bus.f_DataOut = w_f_done ? bus.m_DataOut : 16'h0;
    assign bus.f_Stall   = w_f_req & ~w_f_done;
    assign bus.f_err     = w_f_bad | (w_busy_f & bus.m_err);

    assign bus.d_Done    = w_d_done;
    assign bus.d_DataOut = w_d_done ? bus.m_DataOut : 16'h0;
    assign bus.d_Stall   = w_d_req & ~w_d_done;
    assign bus.d_err     = w_d_bad | (w_busy_d & bus.m_err);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin tie-break.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    mem_arbiter_if bus ();

    mem_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        bus.f_Rd      = 1'b0;
        bus.f_Addr    = 16'h0;
        bus.d_Rd      = 1'b0;
        bus.d_Wr      = 1'b0;
        bus.d_Addr    = 16'h0;
        bus.d_DataIn  = 16'h0;
        bus.m_DataOut = 16'h0;
        bus.m_Done    = 1'b0;
        bus.m_Stall   = 1'b0;
        bus.m_err     = 1'b0;
    endtask

    // Simultaneous f_Rd @0x0002 and d_Rd @0x0004
    task automatic contend(input string tag,
                           input logic  d_first);
        logic [15:0] a1;
        logic [15:0] a2;
        a1 = d_first ? 16'h0004 : 16'h0002;
        a2 = d_first ? 16'h0002 : 16'h0004;
        bus.f_Rd   = 1'b1;
        bus.f_Addr = 16'h0002;
        bus.d_Rd   = 1'b1;
        bus.d_Addr = 16'h0004;
        settle();
        check({tag, ".stall"},
              {bus.f_Stall, bus.d_Stall}, 2'b11);
        tick();
        check({tag, ".cmd1"},
              {bus.m_Rd, bus.m_Addr}, {1'b1, a1});
        bus.m_DataOut = 16'hA001;
        bus.m_Done    = 1'b1;
        settle();
        check({tag, ".done1"},
              {bus.d_Done, bus.f_Done},
              d_first ? 2'b10 : 2'b01);
        check({tag, ".data1"},
              d_first ? bus.d_DataOut : bus.f_DataOut,
              16'hA001);
        check({tag, ".wait2"},
              d_first ? bus.f_Stall : bus.d_Stall, 1);
        tick();
        if (d_first) bus.d_Rd = 1'b0;
        else         bus.f_Rd = 1'b0;
        bus.m_Done    = 1'b0;
        bus.m_DataOut = 16'h0;
        settle();
        check({tag, ".idle"}, bus.m_Rd, 0);
        tick();
        check({tag, ".cmd2"},
              {bus.m_Rd, bus.m_Addr}, {1'b1, a2});
        bus.m_DataOut = 16'hA002;
        bus.m_Done    = 1'b1;
        settle();
        check({tag, ".done2"},
              {bus.d_Done, bus.f_Done},
              d_first ? 2'b01 : 2'b10);
        check({tag, ".data2"},
              d_first ? bus.f_DataOut : bus.d_DataOut,
              16'hA002);
        tick();
        clear_in();
        settle();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        clear_in();
        rst = 1'b0;

        // Reset with a pending fetch
        bus.f_Rd   = 1'b1;
        bus.f_Addr = 16'h0010;
        tick();
        tick();
        check("rst.done",
              {bus.f_Done, bus.d_Done}, 2'b00);
        check("rst.mcmd",
              {bus.m_Rd, bus.m_Wr}, 2'b00);
        check("rst.maddr", bus.m_Addr, 16'h0);
        check("rst.fdata", bus.f_DataOut, 16'h0);
        check("rst.fstall", bus.f_Stall, 1);
        rst = 1'b1;
        tick();
        check("fetch.cmd",
              {bus.m_Rd, bus.m_Addr}, {1'b1, 16'h0010});
        check("fetch.nodone", bus.f_Done, 0);
        bus.m_DataOut = 16'h1234;
        bus.m_Done    = 1'b1;
        settle();
        check("fetch.done", bus.f_Done, 1);
        check("fetch.data", bus.f_DataOut, 16'h1234);
        check("fetch.stall0", bus.f_Stall, 0);
        tick();
        clear_in();
        settle();
        check("fetch.idle",
              {bus.m_Rd, bus.f_Done, bus.f_DataOut},
              {2'b00, 16'h0});

        // Single write, memory done in the third busy cycle
        bus.d_Wr     = 1'b1;
        bus.d_Addr   = 16'h0100;
        bus.d_DataIn = 16'hBEEF;
        settle();
        check("wr.req", {bus.d_Stall, bus.m_Wr}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr.hold",
                  {bus.m_Wr, bus.m_Addr, bus.m_DataIn},
                  {1'b1, 16'h0100, 16'hBEEF});
            check("wr.stall",
                  {bus.d_Stall, bus.d_Done}, 2'b10);
            if (i == 2) begin
                bus.m_Done = 1'b1;
                settle();
                check("wr.done",
                      {bus.d_Done, bus.d_Stall}, 2'b10);
            end
        end
        tick();
        clear_in();
        settle();
        check("wr.idle", {bus.m_Wr, bus.d_Done}, 2'b00);

        // Data was served last: round robin favours fetch
`ifdef ARB_ROUND_ROBIN_EN
        contend("pair1", 1'b0);
`else
        contend("pair1", 1'b1);
`endif

        // Misaligned read and read+write together
        bus.d_Rd   = 1'b1;
        bus.d_Addr = 16'h0003;
        settle();
        check("mis.err",
              {bus.d_err, bus.d_Stall}, 2'b10);
        tick();
        check("mis.nocmd",
              {bus.m_Rd, bus.d_Done}, 2'b00);
        bus.d_Wr   = 1'b1;
        bus.d_Addr = 16'h0004;
        settle();
        check("rw.err",
              {bus.d_err, bus.d_Stall}, 2'b10);
        tick();
        check("rw.nocmd",
              {bus.m_Rd, bus.m_Wr}, 2'b00);
        clear_in();
        bus.f_Rd   = 1'b1;
        bus.f_Addr = 16'h0001;
        settle();
        check("fmis.err",
              {bus.f_err, bus.f_Stall}, 2'b10);
        clear_in();

        // Memory error during a fetch
        bus.f_Rd   = 1'b1;
        bus.f_Addr = 16'h0008;
        settle();
        check("merr.pre", bus.f_err, 0);
        tick();
        bus.m_err = 1'b1;
        settle();
        check("merr.ferr",
              {bus.f_err, bus.d_err}, 2'b10);
        tick();
        check("merr.hold", bus.f_err, 1);
        bus.m_Done = 1'b1;
        settle();
        check("merr.done", bus.f_Done, 1);
        tick();
        clear_in();
        settle();
        check("merr.clear", bus.f_err, 0);

        // Reset two cycles into a data write
        bus.d_Wr     = 1'b1;
        bus.d_Addr   = 16'h0020;
        bus.d_DataIn = 16'h55AA;
        tick();
        tick();
        check("mrst.busy", bus.m_Wr, 1);
        rst = 1'b0;
        settle();
        check("mrst.drop",
              {bus.m_Wr, bus.d_Done, bus.m_Addr},
              {2'b00, 16'h0});
        bus.d_Wr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bus.m_Done = 1'b1;
        settle();
        check("mrst.idle",
              {bus.m_Wr, bus.m_Rd, bus.d_Done}, 3'b000);
        tick();
        clear_in();
        settle();

        // last=0 after reset: data wins in both builds
        contend("pair2", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares a single stalling data memory between the instruction-fetch port (port 0, read-only) and the memory-stage port (port 1, read/write). It sits between fetch/memory stages and the memory instance. It grants one requester at a time, holds the granted command stable until the memory signals Done, and returns data, Done, Stall and error to the correct requester. It also rejects misaligned word accesses before they reach memory.

## Interface
- No parameters; all widths are 16-bit word/address.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- f_Rd  in  1  fetch read request
- f_Addr  in  16  fetch address
- f_DataOut  out  16  fetch read data, valid when f_Done=1
- f_Done  out  1  fetch access complete (one-cycle pulse)
- f_Stall  out  1  fetch must hold request
- f_err  out  1  fetch error
- d_Rd, d_Wr  in  1 each  data read / write request
- d_Addr, d_DataIn  in  16 each  data address / write data
- d_DataOut  out  16  data read data, valid when d_Done=1
- d_Done, d_Stall, d_err  out  1 each  as for fetch
- m_Rd, m_Wr  out  1 each  memory command
- m_Addr, m_DataIn  out  16 each  memory address / write data
- m_DataOut  in  16  memory read data
- m_Done, m_Stall, m_err  in  1 each  memory status

## Operation
- States: IDLE, BUSY_F, BUSY_D (2-bit register). Also a 1-bit `last` register (0 = fetch served last) and latched cmd registers: addr, wdata, rd, wr.
- Valid request:
  - fetch: f_Rd & ~f_Addr[0].
  - data: (d_Rd ^ d_Wr) & ~d_Addr[0].
- Invalid request: misaligned (Addr[0]=1 with Rd/Wr), or d_Rd & d_Wr together.
  - Asserts the port's err combinationally in the same cycle.
  - Never granted; Stall=0, Done=0 for that port.
- IDLE:
  - Only one valid request: grant it at the next edge.
  - Both valid: data port wins (default priority, see Configuration).
  - Grant edge latches Addr/DataIn/Rd/Wr and sets `last`.
- BUSY_x:
  - m_Rd/m_Wr/m_Addr/m_DataIn are driven from the latched registers and held stable until m_Done.
  - On m_Done=1: x_Done=1 and x_DataOut=m_DataOut in that cycle (combinational pass-through). Next state IDLE.
- In IDLE, m_Rd=m_Wr=0, m_Addr=addr register, m_DataIn=wdata register.
- x_DataOut=0 whenever x_Done=0.
- x_Stall=1 while the port has a valid request and is not in its m_Done cycle. This covers waiting in IDLE, waiting behind the other port, and being in BUSY_x.
- x_err=1 when the request is invalid, or when in BUSY_x with m_err=1.
- m_Stall is observed only; it does not change state.
- Requesters hold requests stable while Stall=1. A request dropped while in BUSY_x does not abort the access. The access completes, and its Done pulse is still issued.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, last=0, latched regs=0.
  - All outputs 0: m_Rd, m_Wr, m_Addr, m_DataIn, both Done, both DataOut.
  - Stall/err remain combinational from inputs.
- Reset mid-access drops m_Rd/m_Wr immediately, with no Done pulse. The requester re-issues after reset.
- Latency:
  - Request in IDLE at cycle N: memory command visible at N+1. Done no earlier than N+1 if m_Done arrives in the first busy cycle.
  - Minimum 2 cycles from request to Done.
- Back-to-back: the state always passes through IDLE for one cycle between accesses.
  - If the other port is waiting, its command appears 2 cycles after the previous Done.
- A new request arriving during BUSY is sampled only in IDLE. Its Stall=1 meanwhile.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a simultaneous valid request in IDLE, grant the port not served last (last=0 → data wins; last=1 → fetch wins).
- Undefined: fixed priority, data port always wins ties. The `last` register still exists but is unused for arbitration.

## Test plan
- Reset: rst=0 with f_Rd=1 at 0x0010 → all Done=0, m_Rd=0. After release, m_Rd=1, m_Addr=0x0010 at the next cycle; f_Done pulses with data on m_Done.
- Single write: d_Wr=1, d_Addr=0x0100, d_DataIn=0xBEEF, memory Done after 3 cycles → m_Wr held with fixed addr/data for 3 cycles; d_Done=1 one cycle; d_Stall=1 until then.
- Contention: f_Rd at 0x0002 and d_Rd at 0x0004 in the same cycle.
  - Without macro: data served first; fetch command appears 2 cycles after d_Done.
  - With ARB_ROUND_ROBIN_EN, a second simultaneous pair is served fetch first.
- Misaligned: d_Rd=1, d_Addr=0x0003 → d_err=1 the same cycle, d_Stall=0, no m_Rd. A d_Rd & d_Wr pair gives the same result.
- Memory error: m_err=1 during BUSY_F → f_err=1 in those cycles; d_err unaffected.
- Reset mid-access: rst=0 two cycles into BUSY_D → m_Wr=0 immediately, no d_Done, state IDLE after release.
